// File: rtl/root_tx_arbiter_if.sv
// Root TX arbiter bus: requester handshakes, credit return,
// registered TX output and drain control/status.
interface root_tx_arbiter_if #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 4
);
    logic             comp_req_vld;
    logic [WIDTH-1:0] comp_req_data;
    logic             comp_req_rdy;
    logic             rank_req_vld;
    logic [WIDTH-1:0] rank_req_data;
    logic             rank_req_rdy;
    logic             downstream_credit;
    logic             tx_vld;
    logic [WIDTH-1:0] tx_data;
    logic             drain_req;
    logic             drain_done;
    logic [CNT_W-1:0] credit_avail;
    logic             credit_err;

    modport master (
        output comp_req_vld, comp_req_data,
        input  comp_req_rdy,
        output rank_req_vld, rank_req_data,
        input  rank_req_rdy,
        output downstream_credit,
        input  tx_vld, tx_data,
        output drain_req,
        input  drain_done, credit_avail, credit_err
    );

    modport slave (
        input  comp_req_vld, comp_req_data,
        output comp_req_rdy,
        input  rank_req_vld, rank_req_data,
        output rank_req_rdy,
        input  downstream_credit,
        output tx_vld, tx_data,
        input  drain_req,
        output drain_done, credit_avail, credit_err
    );
endinterface

// File: rtl/root_tx_arbiter.sv
// Round-robin comp/rank arbiter with credit flow control
// toward the root router and a drain handshake.
module root_tx_arbiter #(
    parameter int WIDTH       = 36,
    parameter int CREDIT_INIT = 8,
    parameter int CNT_W       = 4
) (
    input logic               clk,
    input logic               rst_n,
    root_tx_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CREDIT_INIT);

    state_t           r_state;
    logic [CNT_W-1:0] r_credit;
    logic             r_last_comp;
    logic             r_tx_vld;
    logic [WIDTH-1:0] r_tx_data;
    logic             r_done;
    logic             r_err;

    logic             w_can_issue;
    logic             w_gnt_comp;
    logic             w_gnt_rank;
    logic             w_xfer;
    logic             w_overflow;
    logic [CNT_W-1:0] w_credit_nxt;

    // Grants are blocked in reset so rdy never rises while rst_n is low.
    assign w_can_issue = rst_n && (r_state == RUN) &&
                         (r_credit != '0) && !bus.drain_req;

    assign w_gnt_comp = w_can_issue && bus.comp_req_vld &&
                        (!bus.rank_req_vld || !r_last_comp);
    assign w_gnt_rank = w_can_issue && bus.rank_req_vld &&
                        !w_gnt_comp;
    assign w_xfer     = w_gnt_comp || w_gnt_rank;

    assign w_overflow = bus.downstream_credit && !w_xfer &&
                        (r_credit == C_FULL);

    // Next credit: a transfer and a return in one cycle cancel out.
    always_comb begin
        w_credit_nxt = r_credit;
        if (w_xfer && !bus.downstream_credit) begin
            w_credit_nxt = r_credit - 1'b1;
        end else if (!w_xfer && bus.downstream_credit &&
                     (r_credit != C_FULL)) begin
            w_credit_nxt = r_credit + 1'b1;
        end
    end

    // Credit counter, sticky overflow flag and last-grant pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit    <= C_FULL;
            r_err       <= 1'b0;
            r_last_comp <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            if (w_overflow) begin
                r_err <= 1'b1;
            end
            if (w_xfer) begin
                r_last_comp <= w_gnt_comp;
            end
        end
    end

    // Output register: one-cycle latency, zeroed when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_vld  <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_vld <= w_xfer;
            unique case (1'b1)
                w_gnt_comp: r_tx_data <= bus.comp_req_data;
                w_gnt_rank: r_tx_data <= bus.rank_req_data;
                default:    r_tx_data <= '0;
            endcase
        end
    end

    // Drain FSM; DONE is judged on the post-update credit so
    // drain_done rises right after the last return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (bus.drain_req) begin
                        r_state <= DRAIN;
                    end
                    r_done <= 1'b0;
                end
                DRAIN: begin
                    if (!bus.drain_req) begin
                        r_state <= RUN;
                        r_done  <= 1'b0;
                    end else if (w_credit_nxt == C_FULL) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.drain_req) begin
                        r_state <= RUN;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.comp_req_rdy = w_gnt_comp;
    assign bus.rank_req_rdy = w_gnt_rank;
    assign bus.tx_vld       = r_tx_vld;
    assign bus.tx_data      = r_tx_data;
    assign bus.drain_done   = r_done;
    assign bus.credit_avail = r_credit;
    assign bus.credit_err   = r_err;
endmodule

// File: tb/tb_root_tx_arbiter.sv
// Self-checking bench for root_tx_arbiter: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_root_tx_arbiter;
    localparam int W    = 36;
    localparam int CI   = 8;
    localparam int CW   = 4;

    logic clk;
    logic rst_n;

    root_tx_arbiter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    root_tx_arbiter #(
        .WIDTH(W), .CREDIT_INIT(CI), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Behavioural model state
    int         m_credit;
    int         m_mode;
    bit         m_last_comp;
    bit         m_err;
    bit         m_txv;
    logic [W-1:0] m_txd;

    bit         eg_c, eg_r;
    logic       obs_c, obs_r;

    task automatic model_reset();
        m_credit    = CI;
        m_mode      = 0;
        m_last_comp = 1'b0;
        m_err       = 1'b0;
        m_txv       = 1'b0;
        m_txd       = '0;
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // One clock: drive at negedge, sample rdy, advance the model.
    task automatic cyc(input bit c, input bit r,
                       input bit dc, input bit dr);
        bit           can, xfer;
        logic [W-1:0] cd, rd;
        int           nc;
        cd = rnd_data();
        rd = rnd_data();
        bus.comp_req_vld      = c;
        bus.comp_req_data     = cd;
        bus.rank_req_vld      = r;
        bus.rank_req_data     = rd;
        bus.downstream_credit = dc;
        bus.drain_req         = dr;
        can  = (m_mode == 0) && (m_credit > 0) && !dr;
        eg_c = can && c && (!r || !m_last_comp);
        eg_r = can && r && !eg_c;
        #1;
        obs_c = bus.comp_req_rdy;
        obs_r = bus.rank_req_rdy;
        @(posedge clk);
        xfer  = eg_c || eg_r;
        m_txv = xfer;
        m_txd = eg_c ? cd : (eg_r ? rd : '0);
        if (xfer) m_last_comp = eg_c;
        nc = m_credit - int'(xfer) + int'(dc);
        if (nc > CI) begin
            nc    = CI;
            m_err = 1'b1;
        end
        m_credit = nc;
        case (m_mode)
            0: if (dr) m_mode = 1;
            1: if (!dr) m_mode = 0;
               else if (m_credit == CI) m_mode = 2;
            default: if (!dr) m_mode = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.comp_req_vld      = 1'b0;
        bus.comp_req_data     = '0;
        bus.rank_req_vld      = 1'b0;
        bus.rank_req_data     = '0;
        bus.downstream_credit = 1'b0;
        bus.drain_req         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        bus.comp_req_vld = 1'b1;
        bus.rank_req_vld = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.comp_req_rdy !== 1'b0 || bus.rank_req_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rdy: got %b%b want 00",
                     bus.comp_req_rdy, bus.rank_req_rdy);
        end
        n_cmp++;
        if (bus.tx_vld !== 1'b0 || bus.tx_data !== '0) begin
            n_bad++;
            $display("FAIL reset_tx: got vld=%b data=%h want 0/0",
                     bus.tx_vld, bus.tx_data);
        end
        n_cmp++;
        if (bus.credit_avail !== 4'(CI) || bus.drain_done !== 1'b0 ||
            bus.credit_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got cr=%0d dd=%b err=%b want %0d/0/0",
                     bus.credit_avail, bus.drain_done, bus.credit_err, CI);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        bit wc, wr;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0);
            wc = (i < 8) && (i % 2 == 0);
            wr = (i < 8) && (i % 2 == 1);
            n_cmp++;
            if (obs_c !== wc || obs_r !== wr) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got c=%b r=%b want c=%b r=%b",
                         i, obs_c, obs_r, wc, wr);
            end
            n_cmp++;
            if (bus.tx_vld !== m_txv || bus.tx_data !== m_txd) begin
                n_bad++;
                $display("FAIL rr_tx[%0d]: got %b/%h want %b/%h",
                         i, bus.tx_vld, bus.tx_data, m_txv, m_txd);
            end
        end
        n_cmp++;
        if (bus.credit_avail !== 4'd0) begin
            n_bad++;
            $display("FAIL rr_credit: got %0d want 0", bus.credit_avail);
        end
    endtask

    task automatic test_credit_return();
        cyc(1, 1, 1, 0);
        n_cmp++;
        if (obs_c !== 1'b0 || obs_r !== 1'b0) begin
            n_bad++;
            $display("FAIL cr0_grant: got c=%b r=%b want 0 0", obs_c, obs_r);
        end
        cyc(1, 1, 0, 0);
        n_cmp++;
        if (obs_c !== 1'b1 || obs_r !== 1'b0) begin
            n_bad++;
            $display("FAIL cr1_grant: got c=%b r=%b want 1 0", obs_c, obs_r);
        end
        n_cmp++;
        if (bus.tx_vld !== 1'b1 || bus.credit_avail !== 4'd0) begin
            n_bad++;
            $display("FAIL cr1_after: got vld=%b cr=%0d want 1/0",
                     bus.tx_vld, bus.credit_avail);
        end
        cyc(1, 1, 0, 0);
        n_cmp++;
        if (obs_c !== 1'b0 || obs_r !== 1'b0 || bus.tx_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL cr_block: got c=%b r=%b vld=%b want 0 0 0",
                     obs_c, obs_r, bus.tx_vld);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        repeat (5) cyc(1, 0, 0, 0);
        n_cmp++;
        if (bus.credit_avail !== 4'd3) begin
            n_bad++;
            $display("FAIL sc_pre: got %0d want 3", bus.credit_avail);
        end
        cyc(1, 0, 1, 0);
        n_cmp++;
        if (obs_c !== 1'b1 || bus.credit_avail !== 4'd3 ||
            bus.tx_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL sc_both: got gnt=%b cr=%0d vld=%b want 1/3/1",
                     obs_c, bus.credit_avail, bus.tx_vld);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        cyc(0, 0, 1, 0);
        n_cmp++;
        if (bus.credit_avail !== 4'(CI) || bus.credit_err !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf: got cr=%0d err=%b want %0d/1",
                     bus.credit_avail, bus.credit_err, CI);
        end
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 0);
        n_cmp++;
        if (bus.credit_err !== 1'b1 || bus.credit_avail !== 4'(CI)) begin
            n_bad++;
            $display("FAIL ovf_sticky: got err=%b cr=%0d want 1/%0d",
                     bus.credit_err, bus.credit_avail, CI);
        end
    endtask

    task automatic test_drain();
        do_reset();
        repeat (3) cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 1);
        n_cmp++;
        if (obs_c !== 1'b0 || obs_r !== 1'b0 || bus.drain_done !== 1'b0) begin
            n_bad++;
            $display("FAIL dr_first: got c=%b r=%b dd=%b want 0 0 0",
                     obs_c, obs_r, bus.drain_done);
        end
        cyc(1, 1, 1, 1);
        cyc(1, 1, 0, 1);
        cyc(1, 1, 1, 1);
        n_cmp++;
        if (bus.drain_done !== 1'b0 || bus.credit_avail !== 4'd7) begin
            n_bad++;
            $display("FAIL dr_mid: got dd=%b cr=%0d want 0/7",
                     bus.drain_done, bus.credit_avail);
        end
        cyc(1, 1, 1, 1);
        n_cmp++;
        if (bus.drain_done !== 1'b1 || bus.credit_avail !== 4'(CI)) begin
            n_bad++;
            $display("FAIL dr_done: got dd=%b cr=%0d want 1/%0d",
                     bus.drain_done, bus.credit_avail, CI);
        end
        cyc(1, 1, 0, 1);
        n_cmp++;
        if (obs_c !== 1'b0 || obs_r !== 1'b0 || bus.drain_done !== 1'b1) begin
            n_bad++;
            $display("FAIL dr_hold: got c=%b r=%b dd=%b want 0 0 1",
                     obs_c, obs_r, bus.drain_done);
        end
        cyc(1, 1, 0, 0);
        n_cmp++;
        if (bus.drain_done !== 1'b0) begin
            n_bad++;
            $display("FAIL dr_exit: got dd=%b want 0", bus.drain_done);
        end
        cyc(1, 1, 0, 0);
        n_cmp++;
        if (obs_r !== 1'b1 || obs_c !== 1'b0) begin
            n_bad++;
            $display("FAIL dr_resume: got c=%b r=%b want 0 1", obs_c, obs_r);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (6) cyc(1, 1, 0, 0);
        n_cmp++;
        if (bus.credit_avail !== 4'd2 || bus.tx_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_pre: got cr=%0d vld=%b want 2/1",
                     bus.credit_avail, bus.tx_vld);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.tx_vld !== 1'b0 || bus.credit_avail !== 4'(CI) ||
            bus.comp_req_rdy !== 1'b0 || bus.rank_req_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_async: got vld=%b cr=%0d rdy=%b%b want 0/%0d/00",
                     bus.tx_vld, bus.credit_avail,
                     bus.comp_req_rdy, bus.rank_req_rdy, CI);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1, 0, 0);
        n_cmp++;
        if (obs_c !== 1'b1 || obs_r !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_first: got c=%b r=%b want 1 0", obs_c, obs_r);
        end
    endtask

    task automatic test_random();
        bit dr;
        do_reset();
        dr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) dr = !dr;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) < 4, dr);
            n_cmp++;
            if (obs_c !== eg_c || obs_r !== eg_r) begin
                n_bad++;
                $display("FAIL rnd_gnt[%0d]: got c=%b r=%b want c=%b r=%b",
                         i, obs_c, obs_r, eg_c, eg_r);
            end
            n_cmp++;
            if (bus.tx_vld !== m_txv || bus.tx_data !== m_txd) begin
                n_bad++;
                $display("FAIL rnd_tx[%0d]: got %b/%h want %b/%h",
                         i, bus.tx_vld, bus.tx_data, m_txv, m_txd);
            end
            n_cmp++;
            if (bus.credit_avail !== 4'(m_credit) ||
                bus.credit_err !== m_err ||
                bus.drain_done !== (m_mode == 2)) begin
                n_bad++;
                $display("FAIL rnd_st[%0d]: got cr=%0d err=%b dd=%b want %0d/%b/%b",
                         i, bus.credit_avail, bus.credit_err,
                         bus.drain_done, m_credit, m_err, m_mode == 2);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_round_robin();
        test_credit_return();
        test_same_cycle();
        test_overflow();
        test_drain();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
